keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_pkg.sv | 16 +
 rtl/keypad_scan_ctrl_if.sv | 35 +++
 rtl/keypad_row_sync.sv | 30 +++
 rtl/keypad_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared state encoding and default parameters for the keypad scan controller.
package keypad_pkg;

    localparam int unsigned NROWS_DEF           = 4;
    localparam int unsigned NCOLS_DEF           = 4;
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pins and key-event outputs; slave is the controller side, master the keypad/consumer side.
interface keypad_scan_ctrl_if
    import keypad_pkg::*;
#(
    parameter int unsigned NROWS = NROWS_DEF,
    parameter int unsigned NCOLS = NCOLS_DEF
);
    localparam int unsigned CODE_W = $clog2(NROWS * NCOLS);

    logic [NROWS-1:0]  row_raw;
    logic [NCOLS-1:0]  col_drive;
    logic              key_valid;
    logic              key_release;
    logic              key_held;
    logic [CODE_W-1:0] key_code;

    modport slave (
        input  row_raw,
        output col_drive,
        output key_valid,
        output key_release,
        output key_held,
        output key_code
    );

    modport master (
        output row_raw,
        input  col_drive,
        input  key_valid,
        input  key_release,
        input  key_held,
        input  key_code
    );

endinterface

// File: rtl/keypad_row_sync.sv
// Multi-stage flop delay line with synchronous reset to 0; used for row synchronisation
// and for the matching column-tag pipeline.
module keypad_row_sync #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad matrix scanner: rotating column drive, tagged row synchronisation, debounce,
// and press/release event pulses. Build macro KEYSCAN_GHOST_REJECT_EN rejects multi-row samples.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned NROWS           = NROWS_DEF,
    parameter int unsigned NCOLS           = NCOLS_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scan_ctrl_if.slave bus
);

    localparam int unsigned ROW_W  = $clog2(NROWS);
    localparam int unsigned COL_W  = $clog2(NCOLS);
    localparam int unsigned CODE_W = $clog2(NROWS * NCOLS);
    localparam int unsigned CNT_W  = $clog2(SYNC_STAGES + DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] S_SCAN     = ST_SCAN;
    localparam logic [1:0] S_DEBOUNCE = ST_DEBOUNCE;
    localparam logic [1:0] S_HELD     = ST_HELD;
    localparam logic [1:0] S_RELEASE  = ST_RELEASE;

    localparam logic [NCOLS-1:0] COL_FIRST = {1'b1, {(NCOLS-1){1'b0}}};
    localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(SYNC_STAGES + DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Next column toward bit 0, wrapping to the top column.
    function automatic logic [NCOLS-1:0] col_rotate(input logic [NCOLS-1:0] c);
        return {c[0], c[NCOLS-1:1]};
    endfunction

    logic [1:0]        r_state;
    logic [NCOLS-1:0]  r_col_drive;
    logic [CNT_W-1:0]  r_cnt;
    logic [ROW_W-1:0]  r_row_idx;
    logic [COL_W-1:0]  r_col_idx;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;
    logic              r_key_release;
    logic              r_key_held;

    logic [NROWS-1:0]  w_row_sync;
    logic [NCOLS-1:0]  w_col_tag;
    logic              w_any_row;
    logic              w_tag_valid;
    logic              w_multi_row;
    logic              w_cap_bit;
    logic [ROW_W-1:0]  w_low_row;
    logic [COL_W-1:0]  w_tag_col;
    logic [CODE_W-1:0] w_key_code;

    logic [1:0]        w_state_nxt;
    logic [NCOLS-1:0]  w_col_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ROW_W-1:0]  w_row_idx_nxt;
    logic [COL_W-1:0]  w_col_idx_nxt;
    logic [CODE_W-1:0] w_code_nxt;
    logic              w_valid_nxt;
    logic              w_release_nxt;
    logic              w_held_nxt;

    keypad_row_sync #(
        .WIDTH       (NROWS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.row_raw),
        .o_q   (w_row_sync)
    );

    // Column tag travels alongside the rows so each sample knows which column produced it.
    keypad_row_sync #(
        .WIDTH       (NCOLS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tag_line (
        .clk   (clk),
        .reset (reset),
        .i_d   (r_col_drive),
        .o_q   (w_col_tag)
    );

    assign w_any_row   = |w_row_sync;
    assign w_tag_valid = |w_col_tag;
    assign w_cap_bit   = w_row_sync[r_row_idx];
    assign w_key_code  = CODE_W'(r_row_idx) * CODE_W'(NCOLS) + CODE_W'(r_col_idx);

`ifdef KEYSCAN_GHOST_REJECT_EN
    assign w_multi_row = ($countones(w_row_sync) > 1);
`else
    assign w_multi_row = 1'b0;
`endif

    // Lowest set row wins; column index decoded from the one-hot tag.
    always_comb begin
        w_low_row = '0;
        for (int i = int'(NROWS) - 1; i >= 0; i--) begin
            if (w_row_sync[i]) w_low_row = ROW_W'(i);
        end
        w_tag_col = '0;
        for (int i = 0; i < int'(NCOLS); i++) begin
            if (w_col_tag[i]) w_tag_col = COL_W'(i);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col_drive;
        w_cnt_nxt     = r_cnt;
        w_row_idx_nxt = r_row_idx;
        w_col_idx_nxt = r_col_idx;
        w_code_nxt    = r_key_code;
        w_valid_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_held_nxt    = r_key_held;

        case (r_state)
            S_SCAN: begin
                w_col_nxt = col_rotate(r_col_drive);
                if (w_any_row && w_tag_valid && !w_multi_row) begin
                    w_row_idx_nxt = w_low_row;
                    w_col_idx_nxt = w_tag_col;
                    w_col_nxt     = w_col_tag;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_DEBOUNCE;
                end
            end
            // Counter first skips the samples still in flight from the rotating scan.
            S_DEBOUNCE: begin
                if (r_cnt < FLUSH_CNT) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (!w_cap_bit || w_multi_row) begin
                    w_col_nxt   = col_rotate(r_col_drive);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SCAN;
                end else if (r_cnt == DB_LAST) begin
                    w_valid_nxt = 1'b1;
                    w_held_nxt  = 1'b1;
                    w_code_nxt  = w_key_code;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HELD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!w_cap_bit) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (w_cap_bit) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HELD;
                end else if (r_cnt == REL_LAST) begin
                    w_release_nxt = 1'b1;
                    w_held_nxt    = 1'b0;
                    w_col_nxt     = col_rotate(r_col_drive);
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_SCAN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_col_nxt   = COL_FIRST;
                w_cnt_nxt   = '0;
                w_state_nxt = S_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_SCAN;
            r_col_drive   <= COL_FIRST;
            r_cnt         <= '0;
            r_row_idx     <= '0;
            r_col_idx     <= '0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_held    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_col_drive   <= w_col_nxt;
            r_cnt         <= w_cnt_nxt;
            r_row_idx     <= w_row_idx_nxt;
            r_col_idx     <= w_col_idx_nxt;
            r_key_code    <= w_code_nxt;
            r_key_valid   <= w_valid_nxt;
            r_key_release <= w_release_nxt;
            r_key_held    <= w_held_nxt;
        end
    end

    assign bus.col_drive   = r_col_drive;
    assign bus.key_valid   = r_key_valid;
    assign bus.key_release = r_key_release;
    assign bus.key_held    = r_key_held;
    assign bus.key_code    = r_key_code;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: each scenario presses keys on a modelled matrix and predicts
// every cycle's outputs from event timing rules (detect, flush, debounce, release).
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int NR    = int'(NROWS_DEF);
    localparam int NC    = int'(NCOLS_DEF);
    localparam int S     = int'(SYNC_STAGES_DEF);
    localparam int D     = int'(DEBOUNCE_CYCLES_DEF);
    localparam int NCYC  = 80;
    localparam int PRLEN = 128;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    keypad_scan_ctrl_if #(.NROWS(NR), .NCOLS(NC)) bus ();

    keypad_scan_ctrl #(
        .NROWS           (NR),
        .NCOLS           (NC),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int scan_col(input int k);
        return NC - 1 - (k % NC);
    endfunction

    function automatic int wrap(input int x);
        return ((x % NC) + NC) % NC;
    endfunction

    function automatic int lowest(input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [NC-1:0] onehot(input int i);
        logic [NC-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.row_raw = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check(input string tag, input int k, input logic [NC-1:0] e_col,
                         input logic e_valid, input logic e_rel, input logic e_held,
                         input logic [3:0] e_code);
        n_checks++;
        assert (bus.col_drive === e_col) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d col_drive obs=%b exp=%b", tag, k, bus.col_drive, e_col);
        end
        n_checks++;
        assert (bus.key_valid === e_valid) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d key_valid obs=%b exp=%b", tag, k, bus.key_valid, e_valid);
        end
        n_checks++;
        assert (bus.key_release === e_rel) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d key_release obs=%b exp=%b", tag, k, bus.key_release, e_rel);
        end
        n_checks++;
        assert (bus.key_held === e_held) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d key_held obs=%b exp=%b", tag, k, bus.key_held, e_held);
        end
        n_checks++;
        assert (bus.key_code === e_code) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d key_code obs=%0d exp=%0d", tag, k, bus.key_code, e_code);
        end
    endtask

    // Key(s) rm in column c physically pressed during [p0,p0+pl) and [g0,g0+gl), counted from reset.
    task automatic run_scn(input string tag, input int c, input logic [NR-1:0] rm,
                           input int p0, input int pl, input int g0, input int gl);
        bit       pr [PRLEN];
        int       k0, t, hv, e, frz, m, bad, r, ci;
        logic [3:0] ecode;
        for (int k = 0; k < PRLEN; k++)
            pr[k] = ((k >= p0) && (k < p0 + pl)) || ((k >= g0) && (k < g0 + gl));
        k0 = -1; hv = -1; e = -1; frz = -1;
        r  = lowest(rm);
        for (int k = 0; k < NCYC; k++)
            if (k0 < 0 && pr[k] && scan_col(k) == c) k0 = k;
        if (rm == '0) k0 = -1;
`ifdef KEYSCAN_GHOST_REJECT_EN
        if ($countones(rm) > 1) k0 = -1;
`endif
        if (k0 >= 0) begin
            t = k0 + S;
            frz = t + 1;
            m = -1;
            for (int j = 1; j <= D; j++) if (m < 0 && !pr[t + j]) m = t + j;
            if (m >= 0) begin
                e = m + S + 1;
            end else begin
                hv = t + 1 + S + D;
                m = t + D + 1;
                while (e < 0 && m < NCYC) begin
                    while (m < NCYC && pr[m]) m++;
                    bad = -1;
                    for (int j = 1; j <= D; j++) if (bad < 0 && pr[m + j]) bad = m + j;
                    if (bad < 0) e = m + S + D + 1;
                    else m = bad + 1;
                end
            end
        end
        ecode = (r >= 0) ? 4'(r * NC + c) : 4'd0;

        do_reset();
        for (int k = 0; k < NCYC; k++) begin
            if (k > 0) tick();
            if (frz < 0 || k < frz) ci = scan_col(k);
            else if (e < 0 || k < e) ci = c;
            else ci = wrap(c - 1 - (k - e));
            check(tag, k, onehot(ci), (k == hv), (hv >= 0) && (k == e),
                  (hv >= 0) && (k >= hv) && (e < 0 || k < e),
                  ((hv >= 0) && (k >= hv)) ? ecode : 4'd0);
            bus.row_raw = (pr[k] && bus.col_drive[c]) ? rm : '0;
        end
    endtask

    initial begin
        bus.row_raw = '0;

        run_scn("idle",      0, 4'b0000, 0, 0,  0,  0);
        run_scn("press_9",   1, 4'b0100, 0, 40, 0,  0);
        run_scn("short_9",   1, 4'b0100, 2, 4,  0,  0);
        run_scn("glitch_9",  1, 4'b0100, 0, 30, 32, 2);
        run_scn("ghost_r03", 0, 4'b1001, 0, 40, 0,  0);
        run_scn("press_c0",  0, 4'b1000, 3, 30, 0,  0);

        for (int n = 0; n < 12; n++) begin
            int rr, cc, p0, pl;
            logic [NR-1:0] rm;
            rr = int'($urandom_range(NR - 1, 0));
            cc = int'($urandom_range(NC - 1, 0));
            p0 = int'($urandom_range(12, 0));
            pl = int'($urandom_range(24, 0));
            rm = '0;
            rm[rr] = 1'b1;
            run_scn("rand", cc, rm, p0, pl, 0, 0);
        end

        // Reset during DEBOUNCE: key (2,1) held from cycle 0, detected at cycle 4, frozen from cycle 5.
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            if (k == 5) begin
                n_checks++;
                assert (bus.col_drive === 4'b0010) else begin
                    n_errors++;
                    $error("FAIL rst_db_frozen cyc=%0d col_drive obs=%b exp=%b", k, bus.col_drive, 4'b0010);
                end
            end
            if (k == 6) reset = 1'b1;
            bus.row_raw = bus.col_drive[1] ? 4'b0100 : 4'b0000;
        end
        tick();
        check("rst_abort", 7, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        bus.row_raw = '0;
        for (int k = 8; k < 24; k++) begin
            tick();
            check("rst_scan", k, onehot(scan_col(k - 7)), 1'b0, 1'b0, 1'b0, 4'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
